sync_barrier_ctrl: RTL and testbench

Synchronisation barrier controller that sits downstream of the distributed processor cores. It collects each core's `sync_barrier` / `sync_barrier_en_out` request and, when every participating core has arrived at the same barrier, returns a one-cycle `sync_enable` pulse to those cores. Participation per barrier ID comes from a programmable mask table. The block also flags protocol violations and stalled barriers.

---
 rtl/sync_barrier_ctrl.sv | 105 ++++++++++
 tb/tb_sync_barrier_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_barrier_ctrl.sv
// Barrier controller: collects per-core arrival strobes and pulses sync_enable to
// every participant once all cores named in the barrier's mask wait on the same ID.
module sync_barrier_ctrl #(
   parameter int N_CORES            = 4,
   parameter int SYNC_BARRIER_WIDTH = 8,
   parameter int TIMEOUT_WIDTH      = 16
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [N_CORES*SYNC_BARRIER_WIDTH-1:0]  sync_barrier_in,
   input  logic [N_CORES-1:0]                     sync_barrier_en_in,
   output logic [N_CORES-1:0]                     sync_enable,
   input  logic                                   mask_write_en,
   input  logic [SYNC_BARRIER_WIDTH-1:0]          mask_write_addr,
   input  logic [N_CORES-1:0]                     mask_write_data,
   output logic [N_CORES-1:0]                     pending,
   output logic                                   protocol_err,
   output logic                                   timeout_err
);
   localparam int W     = SYNC_BARRIER_WIDTH;
   localparam int DEPTH = 2 ** W;

   logic [N_CORES-1:0]       mask_mem [DEPTH];
   logic [N_CORES-1:0]       pending_reg, pending_next;
   logic [W-1:0]             pend_id_reg [N_CORES];
   logic [W-1:0]             pend_id_next [N_CORES];
   logic [N_CORES-1:0]       sync_enable_reg;
   logic                     protocol_err_reg, timeout_err_reg;
   logic [TIMEOUT_WIDTH-1:0] timeout_cnt_reg, timeout_cnt_next;

   logic [W-1:0]             arr_id [N_CORES];
   logic [N_CORES-1:0]       arr_mask_bit, accept, arr_err;
   logic [N_CORES-1:0]       complete, release_mask;

   // Mask table is read asynchronously: completion must be evaluated every cycle
   // against several entries at once, and reset restores every entry to all ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) mask_mem[k] <= '1;
      end else if (mask_write_en) begin
         mask_mem[mask_write_addr] <= mask_write_data;
      end
   end

   generate
      for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
         assign arr_id[gi]       = sync_barrier_in[gi*W +: W];
         assign arr_mask_bit[gi] = mask_mem[arr_id[gi]][gi];
         assign accept[gi]       = sync_barrier_en_in[gi] & ~pending_reg[gi] & arr_mask_bit[gi];
         assign arr_err[gi]      = sync_barrier_en_in[gi] & (pending_reg[gi] | ~arr_mask_bit[gi]);
         // Released cores are always pending, so accept and release never coincide.
         assign pending_next[gi] = accept[gi] | (pending_reg[gi] & ~release_mask[gi]);
         assign pend_id_next[gi] = accept[gi] ? arr_id[gi] : pend_id_reg[gi];
      end
   endgenerate

   always_comb begin
      logic [N_CORES-1:0] m;
      logic [N_CORES-1:0] match;
      complete     = '0;
      release_mask = '0;
      m            = '0;
      match        = '0;
      for (int i = 0; i < N_CORES; i++) begin
         m = mask_mem[pend_id_reg[i]];
         for (int j = 0; j < N_CORES; j++) begin
            match[j] = pending_reg[j] && (pend_id_reg[j] == pend_id_reg[i]);
         end
         complete[i] = pending_reg[i] && ((match | ~m) == '1);
         if (complete[i]) release_mask = release_mask | m;
      end
   end

   always_comb begin
      if (pending_reg == '0 || release_mask != '0)
         timeout_cnt_next = '0;
      else if (timeout_cnt_reg == '1)
         timeout_cnt_next = timeout_cnt_reg;
      else
         timeout_cnt_next = timeout_cnt_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_reg      <= '0;
         sync_enable_reg  <= '0;
         protocol_err_reg <= 1'b0;
         timeout_err_reg  <= 1'b0;
         timeout_cnt_reg  <= '0;
         for (int i = 0; i < N_CORES; i++) pend_id_reg[i] <= '0;
      end else begin
         pending_reg     <= pending_next;
         sync_enable_reg <= release_mask;
         timeout_cnt_reg <= timeout_cnt_next;
         for (int i = 0; i < N_CORES; i++) pend_id_reg[i] <= pend_id_next[i];
         if (arr_err != '0) protocol_err_reg <= 1'b1;
         if (timeout_cnt_next == '1) timeout_err_reg <= 1'b1;
      end
   end

   assign sync_enable  = sync_enable_reg;
   assign pending      = pending_reg;
   assign protocol_err = protocol_err_reg;
   assign timeout_err  = timeout_err_reg;
endmodule

// File: tb/tb_sync_barrier_ctrl.sv
// Table-driven bench for sync_barrier_ctrl: each vector is one clock cycle of
// stimulus plus the outputs expected in the following cycle.
module tb_sync_barrier_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] sync_barrier_in;
   logic [3:0]  sync_barrier_en_in;
   logic [3:0]  sync_enable;
   logic        mask_write_en;
   logic [7:0]  mask_write_addr;
   logic [3:0]  mask_write_data;
   logic [3:0]  pending;
   logic        protocol_err;
   logic        timeout_err;

   sync_barrier_ctrl #(.N_CORES(4), .SYNC_BARRIER_WIDTH(8), .TIMEOUT_WIDTH(4)) dut (
      .clk(clk), .reset(reset),
      .sync_barrier_in(sync_barrier_in), .sync_barrier_en_in(sync_barrier_en_in),
      .sync_enable(sync_enable),
      .mask_write_en(mask_write_en), .mask_write_addr(mask_write_addr),
      .mask_write_data(mask_write_data),
      .pending(pending), .protocol_err(protocol_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  en;
      logic [31:0] ids;
      logic        we;
      logic [7:0]  wa;
      logic [3:0]  wd;
      logic [3:0]  se;
      logic [3:0]  pend;
      logic        perr;
      logic        terr;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [31:0] ids4(int a, int b, int c, int d);
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   task automatic add(string name, logic rst, logic [3:0] en, logic [31:0] ids,
                      logic we, logic [7:0] wa, logic [3:0] wd,
                      logic [3:0] se, logic [3:0] pend, logic perr, logic terr);
      vec_t v;
      v.name = name; v.rst = rst; v.en = en; v.ids = ids; v.we = we; v.wa = wa; v.wd = wd;
      v.se = se; v.pend = pend; v.perr = perr; v.terr = terr;
      vecs.push_back(v);
   endtask

   task automatic idle(string name, logic [3:0] se, logic [3:0] pend, logic perr);
      add(name, 1'b0, 4'b0, 32'd0, 1'b0, 8'd0, 4'b0, se, pend, perr, 1'b0);
   endtask

   task automatic check_one();
      vec_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (sync_enable !== e.se || pending !== e.pend ||
          protocol_err !== e.perr || timeout_err !== e.terr) begin
         n_err++;
         $display("FAIL %s: got se=%b pend=%b perr=%b terr=%b, want se=%b pend=%b perr=%b terr=%b",
                  e.name, sync_enable, pending, protocol_err, timeout_err,
                  e.se, e.pend, e.perr, e.terr);
      end else begin
         $display("ok   %s: se=%b pend=%b perr=%b terr=%b",
                  e.name, sync_enable, pending, protocol_err, timeout_err);
      end
   endtask

   task automatic step(input vec_t v);
      reset              = v.rst;
      sync_barrier_en_in = v.en;
      sync_barrier_in    = v.ids;
      mask_write_en      = v.we;
      mask_write_addr    = v.wa;
      mask_write_data    = v.wd;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      check_one();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   lat;
      reset = 1'b1; sync_barrier_en_in = '0; sync_barrier_in = '0;
      mask_write_en = 1'b0; mask_write_addr = '0; mask_write_data = '0;

      add("reset0", 1, 4'b0, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
      add("reset1", 1, 4'b0, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
      idle("idle", 4'b0, 4'b0, 0);
      // Basic 4-core barrier on ID 5, staggered arrivals
      add("A c0 id5", 0, 4'b0001, ids4(5, 0, 0, 0), 0, 0, 0, 4'b0, 4'b0001, 0, 0);
      idle("A wait1", 4'b0, 4'b0001, 0);
      add("A c1c2 id5", 0, 4'b0110, ids4(0, 5, 5, 0), 0, 0, 0, 4'b0, 4'b0111, 0, 0);
      idle("A wait2", 4'b0, 4'b0111, 0);
      idle("A wait3", 4'b0, 4'b0111, 0);
      add("A c3 id5", 0, 4'b1000, ids4(0, 0, 0, 5), 0, 0, 0, 4'b0, 4'b1111, 0, 0);
      idle("A release", 4'b1111, 4'b0, 0);
      idle("A after", 4'b0, 4'b0, 0);
      // Disjoint barriers releasing together
      add("B wr m1", 0, 4'b0, 0, 1, 8'd1, 4'b0011, 4'b0, 4'b0, 0, 0);
      add("B wr m2", 0, 4'b0, 0, 1, 8'd2, 4'b1100, 4'b0, 4'b0, 0, 0);
      add("B arrive", 0, 4'b1111, ids4(1, 1, 2, 2), 0, 0, 0, 4'b0, 4'b1111, 0, 0);
      idle("B release", 4'b1111, 4'b0, 0);
      idle("B after", 4'b0, 4'b0, 0);
      // ID mismatch holds everyone; matched rerun after reset releases
      add("C mismatch", 0, 4'b1111, ids4(3, 3, 3, 4), 0, 0, 0, 4'b0, 4'b1111, 0, 0);
      idle("C hold1", 4'b0, 4'b1111, 0);
      idle("C hold2", 4'b0, 4'b1111, 0);
      idle("C hold3", 4'b0, 4'b1111, 0);
      add("C reset", 1, 4'b0, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
      add("C matched", 0, 4'b1111, ids4(3, 3, 3, 3), 0, 0, 0, 4'b0, 4'b1111, 0, 0);
      idle("C release", 4'b1111, 4'b0, 0);
      idle("C after", 4'b0, 4'b0, 0);
      // Protocol errors: non-participant, then single-core release, re-arrival, duplicate
      add("D wr m7", 0, 4'b0, 0, 1, 8'd7, 4'b0001, 4'b0, 4'b0, 0, 0);
      add("D c1 nonpart", 0, 4'b0010, ids4(0, 7, 0, 0), 0, 0, 0, 4'b0, 4'b0, 1, 0);
      idle("D sticky", 4'b0, 4'b0, 1);
      add("D reset", 1, 4'b0, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
      add("D wr m7 again", 0, 4'b0, 0, 1, 8'd7, 4'b0001, 4'b0, 4'b0, 0, 0);
      add("D c0 arrive", 0, 4'b0001, ids4(7, 0, 0, 0), 0, 0, 0, 4'b0, 4'b0001, 0, 0);
      idle("D c0 release", 4'b0001, 4'b0, 0);
      add("D c0 rearrive", 0, 4'b0001, ids4(7, 0, 0, 0), 0, 0, 0, 4'b0, 4'b0001, 0, 0);
      add("D c0 dup", 0, 4'b0001, ids4(7, 0, 0, 0), 0, 0, 0, 4'b0001, 4'b0, 1, 0);
      idle("D after", 4'b0, 4'b0, 1);
      // Zero mask can never be joined
      add("Z reset", 1, 4'b0, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
      add("Z wr m10", 0, 4'b0, 0, 1, 8'd10, 4'b0000, 4'b0, 4'b0, 0, 0);
      add("Z c2 id10", 0, 4'b0100, ids4(0, 0, 10, 0), 0, 0, 0, 4'b0, 4'b0, 1, 0);
      // Arrival in the write cycle sees the old (all ones) mask
      add("W reset", 1, 4'b0, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
      add("W race", 0, 4'b0010, ids4(0, 11, 0, 0), 1, 8'd11, 4'b0001, 4'b0, 4'b0010, 0, 0);
      idle("W stuck", 4'b0, 4'b0010, 0);
      // Mask rewrite completes a pending barrier; reset drops an in-flight release
      add("F reset", 1, 4'b0, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
      add("F arrive", 0, 4'b0011, ids4(9, 9, 0, 0), 0, 0, 0, 4'b0, 4'b0011, 0, 0);
      idle("F wait", 4'b0, 4'b0011, 0);
      add("F wr m9", 0, 4'b0, 0, 1, 8'd9, 4'b0011, 4'b0, 4'b0011, 0, 0);
      idle("F release", 4'b0011, 4'b0, 0);
      idle("F after", 4'b0, 4'b0, 0);
      add("F2 reset", 1, 4'b0, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
      add("F2 arrive", 0, 4'b0011, ids4(9, 9, 0, 0), 0, 0, 0, 4'b0, 4'b0011, 0, 0);
      idle("F2 wait", 4'b0, 4'b0011, 0);
      add("F2 wr m9", 0, 4'b0, 0, 1, 8'd9, 4'b0011, 4'b0, 4'b0011, 0, 0);
      add("F2 reset mid", 1, 4'b0, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
      idle("F2 dropped", 4'b0, 4'b0, 0);
      add("F2 mask restored", 0, 4'b0001, ids4(9, 0, 0, 0), 0, 0, 0, 4'b0, 4'b0001, 0, 0);
      idle("F2 no release", 4'b0, 4'b0001, 0);

      foreach (vecs[k]) step(vecs[k]);

      // Timeout: core 0 alone on a 2-core barrier
      add("T reset", 1, 4'b0, 0, 0, 0, 0, 4'b0, 4'b0, 0, 0);
      step(vecs[$]);
      add("T wr m6", 0, 4'b0, 0, 1, 8'd6, 4'b0011, 4'b0, 4'b0, 0, 0);
      step(vecs[$]);
      add("T c0 arrive", 0, 4'b0001, ids4(6, 0, 0, 0), 0, 0, 0, 4'b0, 4'b0001, 0, 0);
      step(vecs[$]);
      for (int i = 1; i <= 20; i++) begin
         v = vecs[$];
         v.name = $sformatf("T stall %0d", i);
         v.en = 4'b0; v.ids = '0; v.we = 1'b0;
         v.se = 4'b0; v.pend = 4'b0001; v.perr = 1'b0;
         v.terr = (i >= 15);
         step(v);
      end

      // Late partner still releases normally; timeout_err stays sticky
      sync_barrier_en_in = 4'b0010;
      sync_barrier_in    = ids4(0, 6, 0, 0);
      @(posedge clk);
      #1;
      sync_barrier_en_in = 4'b0;
      lat = 1;
      while (sync_enable == 4'b0 && lat < 6) begin
         @(posedge clk);
         #1;
         lat++;
      end
      n_vec++;
      if (sync_enable !== 4'b0011 || lat != 2) begin
         n_err++;
         $display("FAIL T late release: got se=%b after %0d cycles, want se=0011 after 2 cycles",
                  sync_enable, lat);
      end else begin
         $display("ok   T late release: se=%b after %0d cycles", sync_enable, lat);
      end
      n_vec++;
      if (timeout_err !== 1'b1 || pending !== 4'b0) begin
         n_err++;
         $display("FAIL T sticky: got terr=%b pend=%b, want terr=1 pend=0000",
                  timeout_err, pending);
      end else begin
         $display("ok   T sticky: terr=%b pend=%b", timeout_err, pending);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
